// File: rtl/crc_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : crc_pkg                                                      |
// | Description : Shared widths, engine timing and FSM state encoding for the  |
// |               CRC job arbiter.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package crc_pkg;

  localparam int CRC_DATA_W     = 40;
  localparam int CRC_W          = 16;
  localparam int CRC_MASK_W     = 17;
  localparam int CRC_ENGINE_LAT = 42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/crc_job_arbiter_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Combinational round-robin picker. Grants the first request   |
// |               at or after ptr, wrapping modulo N.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Scan requesters starting at ptr; the first valid one wins.
  always_comb begin
    logic [ID_W-1:0] k;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = '0;
    for (int off = 0; off < N; off++) begin
      k = ID_W'((int'(ptr) + off) % N);
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/crc_job_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : crc_job_arbiter                                              |
// | Description : Shares one serial CRC engine between N requesters. Grants    |
// |               round-robin, loads one job at a time, pulses the engine      |
// |               write strobe, captures the result and returns it tagged with |
// |               the requester index.                                         |
// |               Optional macro CRC_ARB_TIMEOUT_EN adds a WAIT watchdog that  |
// |               returns an error response after TIMEOUT cycles.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module crc_job_arbiter
  import crc_pkg::*;
#(
  parameter int N       = 4,
  parameter int ID_W    = (N > 1) ? $clog2(N) : 1,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N-1:0]            req_valid_i,
  input  logic [N*CRC_DATA_W-1:0] req_data_i,
  input  logic [N*CRC_MASK_W-1:0] req_mask_i,
  output logic [N-1:0]            req_ready_o,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [CRC_W-1:0]        rsp_crc_o,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic                    rsp_err_o,
  output logic                    busy_o,
  output logic [CRC_DATA_W-1:0]   crc_data_o,
  output logic                    crc_we_o,
  output logic [CRC_MASK_W-1:0]   crc_mask_o,
  input  logic [CRC_W-1:0]        crc_out_i,
  input  logic                    crc_valid_i
);

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic [N-1:0]          grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  grant_any;
  logic [ID_W-1:0]       next_ptr;
  logic [CRC_DATA_W-1:0] sel_data;
  logic [CRC_MASK_W-1:0] sel_mask;

`ifdef CRC_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0] wd_cnt;
`endif

  rr_arbiter #(
    .N    (N),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .req   (req_valid_i),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Grants are only offered while idle; accept = valid & ready.
  assign req_ready_o = (state == ST_IDLE) ? grant : '0;
  assign busy_o      = (state != ST_IDLE);
  assign sel_data    = req_data_i[grant_idx * CRC_DATA_W +: CRC_DATA_W];
  assign sel_mask    = req_mask_i[grant_idx * CRC_MASK_W +: CRC_MASK_W];
  assign next_ptr    = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;

`ifndef CRC_ARB_TIMEOUT_EN
  assign rsp_err_o = 1'b0;
`endif

  // Job sequencer: accept, strobe engine, wait for result, hold response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      rsp_valid_o <= 1'b0;
      rsp_crc_o   <= '0;
      rsp_id_o    <= '0;
      crc_data_o  <= '0;
      crc_we_o    <= 1'b0;
      crc_mask_o  <= '0;
`ifdef CRC_ARB_TIMEOUT_EN
      rsp_err_o   <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      crc_we_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            // The mask register is the only path to the engine's mask input,
            // so it must not move again until the next accept.
            crc_data_o <= sel_data;
            crc_mask_o <= sel_mask;
            rsp_id_o   <= grant_idx;
            rr_ptr     <= next_ptr;
            crc_we_o   <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
`ifdef CRC_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (crc_valid_i) begin
            rsp_crc_o   <= crc_out_i;
            rsp_valid_o <= 1'b1;
            state       <= ST_RESP;
`ifdef CRC_ARB_TIMEOUT_EN
            rsp_err_o   <= 1'b0;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            rsp_crc_o   <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
